mdu_ctrl: RTL and testbench

Sequential multiply/divide-unit controller that replaces the single-cycle combinational multiplier and the two always-enabled hi/lo registers in the execute stage. It runs a `WIDTH`-cycle radix-2 shift-add multiply, signed or unsigned, and owns the HI/LO architectural registers. While an operation is in flight, it stalls the pipeline for any `mfhi`/`mflo` read or any new multiply issue. It sits beside the ALU in execute, is driven by decode control, and its `rd_data` feeds the writeback mux in place of the old hi/lo select.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_shift_add.sv | 52 +++++
 rtl/mdu_ctrl.sv | 140 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide-unit controller.
//   MDU_WIDTH   - default operand width (HI and LO are each this wide)
//   MDU_CNT_W   - width of the RUN step counter for the default width
//   mdu_state_t - controller state encoding {IDLE, RUN, FIN}
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_shift_add.sv
// mdu_shift_add: radix-2 shift-add multiply datapath.
// Holds the 2*WIDTH accumulator, the multiplicand and the multiplier.
//   clk, reset    - clock and synchronous active-high reset
//   i_load        - capture operands and clear the accumulator
//   i_step        - one add/shift step
//   i_mcand       - multiplicand (already a magnitude for signed ops)
//   i_mplier      - multiplier (already a magnitude for signed ops)
//   o_acc         - accumulator; holds the unsigned product after WIDTH steps
module mdu_shift_add
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH:0]     w_sum;

    // Upper half plus the gated multiplicand; the extra bit keeps the carry
    // so it can be shifted back in at the top of the accumulator.
    always_comb begin
        w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
              + {1'b0, r_mcand & {WIDTH{r_mplier[0]}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
        end else if (i_step) begin
            r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequential multiply controller owning the HI/LO registers.
// A multiply takes WIDTH RUN cycles plus one FIN cycle; meanwhile any
// mfhi/mflo read or new multiply issue stalls the pipeline.
//   clk, reset         - clock and synchronous active-high reset
//   start, op_signed   - issue mult (signed) / multu (unsigned)
//   x, y               - multiplicand / multiplier, sampled with start
//   kill               - flush; aborts an in-flight multiply without writing
//   rd_req, rd_hi      - mfhi/mflo request and HI/LO select
//   rd_data            - selected HI or LO (combinational)
//   hi_q, lo_q         - architectural HI/LO registers
//   busy, stall, done  - status: in flight, hold pipeline, result written
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             kill,
    input  logic             rd_req,
    input  logic             rd_hi,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_t         r_state;
    mdu_state_t         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_load;
    logic               w_step;
    logic               w_write;
    logic [WIDTH-1:0]   w_mag_x;
    logic [WIDTH-1:0]   w_mag_y;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_product;

    // Magnitudes for signed ops. The most negative value negates to itself,
    // which is exactly its magnitude when read as unsigned.
    assign w_mag_x = (op_signed && x[WIDTH-1]) ? -x : x;
    assign w_mag_y = (op_signed && y[WIDTH-1]) ? -y : y;

    mdu_shift_add #(
        .WIDTH    (WIDTH)
    ) u_shift_add (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_mcand  (w_mag_x),
        .i_mplier (w_mag_y),
        .o_acc    (w_acc)
    );

    assign w_product = r_neg ? -w_acc : w_acc;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !kill) begin
                    w_load       = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (kill) begin
                    w_state_next = IDLE;
                end else begin
                    w_step     = 1'b1;
                    w_cnt_next = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_state_next = FIN;
                    end
                end
            end
            FIN: begin
                w_state_next = IDLE;
                if (!kill) begin
                    w_write = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_write;
            if (w_load) begin
                r_neg <= op_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            end
            if (w_write) begin
                r_hi <= w_product[2*WIDTH-1:WIDTH];
                r_lo <= w_product[WIDTH-1:0];
            end
        end
    end

    assign busy    = (r_state != IDLE);
    // A read issued in the same cycle as start sees the old HI/LO, since
    // busy is still low and the registers only change WIDTH+1 edges later.
    assign stall   = busy & (rd_req | start);
    assign rd_data = rd_hi ? r_hi : r_lo;
    assign hi_q    = r_hi;
    assign lo_q    = r_lo;
    assign done    = r_done;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (WIDTH = 32).
// Inputs are driven and outputs checked on the falling clock edge.
module tb_mdu_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op_signed;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         kill;
    logic         rd_req;
    logic         rd_hi;
    logic [W-1:0] rd_data;
    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;
    logic         busy;
    logic         stall;
    logic         done;

    int tests_run    = 0;
    int tests_failed = 0;

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_signed (op_signed),
        .x         (x),
        .y         (y),
        .kill      (kill),
        .rd_req    (rd_req),
        .rd_hi     (rd_hi),
        .rd_data   (rd_data),
        .hi_q      (hi_q),
        .lo_q      (lo_q),
        .busy      (busy),
        .stall     (stall),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Present one start for a single cycle; returns on the negedge after E0.
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        op_signed = sgn;
        x         = a;
        y         = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issue and wait to the negedge right after HI/LO are written (E0+W+1).
    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(sgn, a, b);
        repeat (W + 1) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; rd_req = 1'b1; rd_hi = 1'b0; kill = 1'b0;
        op_signed = 1'b0; x = 32'd5; y = 32'd6;
        repeat (3) @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if ({hi_q, lo_q} !== 64'h0) begin tests_failed++; $display("FAIL reset_hilo: got %h expected 0", {hi_q, lo_q}); end
        reset = 1'b0; start = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        $display("[TB] reset: busy=%b hi=%h lo=%h", busy, hi_q, lo_q);
    endtask

    task automatic test_unsigned;
        int busy_cycles = 0;
        int done_cycles = 0;
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cycles++;
            if (done) done_cycles++;
            if (i == 32) begin
                tests_run++; if (hi_q !== 32'h0 || busy !== 1'b1) begin tests_failed++; $display("FAIL umax_fin_early: got hi=%h busy=%b expected hi=0 busy=1", hi_q, busy); end
            end
            if (i == 33) begin
                tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL umax_done_time: got done=%b busy=%b expected 1/0", done, busy); end
                tests_run++; if (hi_q !== 32'hFFFF_FFFE || lo_q !== 32'h0000_0001) begin tests_failed++; $display("FAIL umax_product: got %h_%h expected fffffffe_00000001", hi_q, lo_q); end
            end
            @(negedge clk);
        end
        tests_run++; if (busy_cycles != 33) begin tests_failed++; $display("FAIL umax_busy_len: got %0d expected 33", busy_cycles); end
        tests_run++; if (done_cycles != 1) begin tests_failed++; $display("FAIL umax_done_count: got %0d expected 1", done_cycles); end
        $display("[TB] multu ffffffff*ffffffff -> %h_%h busy=%0d", hi_q, lo_q, busy_cycles);
        run_op(1'b0, 32'h1234_5678, 32'h0000_0010);
        tests_run++; if (hi_q !== 32'h1 || lo_q !== 32'h2345_6780) begin tests_failed++; $display("FAIL multu_shift: got %h_%h expected 00000001_23456780", hi_q, lo_q); end
        $display("[TB] multu 12345678*10 -> %h_%h", hi_q, lo_q);
    endtask

    task automatic test_signed_corner;
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000);
        tests_run++; if (hi_q !== 32'h4000_0000 || lo_q !== 32'h0) begin tests_failed++; $display("FAIL signed_corner: got %h_%h expected 40000000_00000000", hi_q, lo_q); end
        $display("[TB] mult 80000000*80000000 -> %h_%h", hi_q, lo_q);
    endtask

    task automatic test_signed;
        run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
        tests_run++; if (hi_q !== 32'hFFFF_FFFF || lo_q !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL signed_neg1: got %h_%h expected ffffffff_ffffffff", hi_q, lo_q); end
        $display("[TB] mult ffffffff*1 -> %h_%h", hi_q, lo_q);
        run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0007);
        tests_run++; if (hi_q !== 32'hFFFF_FFFF || lo_q !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL signed_m3x7: got %h_%h expected ffffffff_ffffffeb", hi_q, lo_q); end
        $display("[TB] mult fffffffd*7 -> %h_%h", hi_q, lo_q);
    endtask

    task automatic test_read_stall;
        int stall_cycles = 0;
        // Read and start together in IDLE: no stall, old LO/HI visible.
        start = 1'b1; op_signed = 1'b0; x = 32'd3; y = 32'd5;
        rd_req = 1'b1; rd_hi = 1'b1;
        #1;
        tests_run++; if (stall !== 1'b0 || rd_data !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL read_idle_hi: got stall=%b data=%h expected 0/ffffffff", stall, rd_data); end
        rd_hi = 1'b0;
        #1;
        tests_run++; if (rd_data !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL read_idle_lo: got %h expected ffffffeb", rd_data); end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 33; i++) begin
            if (stall) stall_cycles++;
            if (i == 4) begin
                start = 1'b1; x = 32'd100; y = 32'd100;
                #1;
                tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL start_busy_stall: got %b expected 1", stall); end
            end
            @(negedge clk);
            start = 1'b0;
        end
        tests_run++; if (stall_cycles != 33) begin tests_failed++; $display("FAIL read_stall_len: got %0d expected 33", stall_cycles); end
        tests_run++; if (stall !== 1'b0 || rd_data !== 32'd15) begin tests_failed++; $display("FAIL read_unstalled: got stall=%b data=%h expected 0/0000000f", stall, rd_data); end
        rd_req = 1'b0;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0 || lo_q !== 32'd15) begin tests_failed++; $display("FAIL busy_start_ignored: got busy=%b lo=%h expected 0/0000000f", busy, lo_q); end
        $display("[TB] read stall 3*5: stall_cycles=%0d lo=%h", stall_cycles, lo_q);
    endtask

    task automatic test_back_to_back;
        // start held high the whole time, as a stalled pipeline would.
        start = 1'b1; op_signed = 1'b0; x = 32'd2; y = 32'd3;
        @(negedge clk);
        x = 32'd4; y = 32'd5;
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL b2b_stall: got %b expected 1", stall); end
        repeat (33) @(negedge clk);
        tests_run++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b1 || lo_q !== 32'd6) begin tests_failed++; $display("FAIL b2b_first: got busy=%b stall=%b done=%b lo=%h expected 0/0/1/00000006", busy, stall, done, lo_q); end
        @(negedge clk);
        start = 1'b0;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
        repeat (33) @(negedge clk);
        tests_run++; if (done !== 1'b1 || hi_q !== 32'h0 || lo_q !== 32'd20) begin tests_failed++; $display("FAIL b2b_second: got done=%b %h_%h expected 1 00000000_00000014", done, hi_q, lo_q); end
        $display("[TB] back-to-back 2*3 then 4*5 -> lo=%h", lo_q);
    endtask

    task automatic test_abort;
        int done_seen = 0;
        run_op(1'b0, 32'h8000_0001, 32'h0000_0002);
        tests_run++; if (hi_q !== 32'h1 || lo_q !== 32'h2) begin tests_failed++; $display("FAIL abort_setup: got %h_%h expected 00000001_00000002", hi_q, lo_q); end
        // Kill at RUN cycle 10.
        issue(1'b0, 32'd7, 32'd9);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_run_idle: got busy=%b expected 0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        tests_run++; if (done_seen != 0 || hi_q !== 32'h1 || lo_q !== 32'h2) begin tests_failed++; $display("FAIL abort_run_keep: got done_seen=%0d %h_%h expected 0 00000001_00000002", done_seen, hi_q, lo_q); end
        // Kill in FIN.
        issue(1'b0, 32'd7, 32'd9);
        repeat (32) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        tests_run++; if (busy !== 1'b0 || done !== 1'b0 || hi_q !== 32'h1 || lo_q !== 32'h2) begin tests_failed++; $display("FAIL abort_fin: got busy=%b done=%b %h_%h expected 0/0 00000001_00000002", busy, done, hi_q, lo_q); end
        // start with kill in IDLE is dropped.
        start = 1'b1; kill = 1'b1; x = 32'd7; y = 32'd9;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL start_kill_idle: got busy=%b expected 0", busy); end
        $display("[TB] abort: hi=%h lo=%h", hi_q, lo_q);
    endtask

    task automatic test_reset_mid;
        issue(1'b0, 32'hFFFF, 32'hFFFF);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++; if (busy !== 1'b0 || hi_q !== 32'h0 || lo_q !== 32'h0) begin tests_failed++; $display("FAIL reset_mid: got busy=%b %h_%h expected 0 00000000_00000000", busy, hi_q, lo_q); end
        run_op(1'b0, 32'd2, 32'd3);
        tests_run++; if (hi_q !== 32'h0 || lo_q !== 32'd6) begin tests_failed++; $display("FAIL reset_mid_after: got %h_%h expected 00000000_00000006", hi_q, lo_q); end
        $display("[TB] reset mid-run then 2*3 -> lo=%h", lo_q);
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed_corner;
        test_signed;
        test_read_stall;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
